// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit, valid/ready flow control.
// Optional macro BARREL_SHIFT_PIPE_SRA_EN enables arithmetic right shift on op 100 (otherwise op 100 = SRL).
module barrel_shift_pipe #(
  parameter int WIDTH = 64,
  parameter int LOG2W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_samt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (LOG2W != $clog2(WIDTH)) begin : g_bad_log2w
    $error("barrel_shift_pipe: LOG2W must equal log2(WIDTH)");
  end
  if (WIDTH < 4 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("barrel_shift_pipe: WIDTH must be a power of two in 4..128");
  end

  // One conditional step of the shift; sh is the stage weight 2^k (never 0 or WIDTH).
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sgn,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sgn}} << (WIDTH - sh);
    case (op)
      3'b001:  return (d >> sh) | (d << (WIDTH - sh));
      3'b010:  return d << sh;
      3'b011:  return d >> sh;
      3'b100:  return (d >> sh) | fill;
      default: return (d << sh) | (d >> (WIDTH - sh));
    endcase
  endfunction

  logic [LOG2W-1:0] vld;
  logic [WIDTH-1:0] dat [LOG2W];
  logic [2:0]       opc [LOG2W];
  logic [LOG2W-1:0] amt [LOG2W];
`ifdef BARREL_SHIFT_PIPE_SRA_EN
  logic             sgn [LOG2W];
`endif
  logic [LOG2W:0]   ld;

  // ld[k]: stage k may load this cycle (empty, or its contents move on); ld[LOG2W] is the sink.
  always_comb begin
    ld = '0;
    ld[LOG2W] = out_ready;
    for (int unsigned i = 0; i < LOG2W; i++) begin
      ld[LOG2W-1-i] = !vld[LOG2W-1-i] || ld[LOG2W-i];
    end
  end

  assign in_ready  = ld[0] && !rst;
  assign out_valid = vld[LOG2W-1];
  assign out_data  = dat[LOG2W-1];

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;
    logic [2:0]       src_op;
    logic [LOG2W-1:0] src_amt;
    logic             src_s;
    logic [WIDTH-1:0] nxt_d;
    logic             v_q;
    logic [WIDTH-1:0] d_q;
    logic [2:0]       op_q;
    logic [LOG2W-1:0] amt_q;

    if (k == 0) begin : g_first
      assign src_v   = in_valid;
      assign src_d   = in_data;
      assign src_op  = in_op;
      assign src_amt = in_samt;
`ifdef BARREL_SHIFT_PIPE_SRA_EN
      assign src_s   = in_data[WIDTH-1];
`else
      assign src_s   = 1'b0;
`endif
    end else begin : g_next
      assign src_v   = vld[k-1];
      assign src_d   = dat[k-1];
      assign src_op  = opc[k-1];
      assign src_amt = amt[k-1];
`ifdef BARREL_SHIFT_PIPE_SRA_EN
      assign src_s   = sgn[k-1];
`else
      assign src_s   = 1'b0;
`endif
    end

    always_comb begin
      nxt_d = src_d;
      if (src_amt[k]) nxt_d = shift_step(src_d, src_op, src_s, 1 << k);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        d_q   <= '0;
        op_q  <= '0;
        amt_q <= '0;
      end else if (ld[k]) begin
        v_q   <= src_v;
        d_q   <= nxt_d;
        op_q  <= src_op;
        amt_q <= src_amt;
      end
    end

`ifdef BARREL_SHIFT_PIPE_SRA_EN
    logic s_q;
    always_ff @(posedge clk) begin
      if (rst)        s_q <= 1'b0;
      else if (ld[k]) s_q <= src_s;
    end
    assign sgn[k] = s_q;
`endif

    assign vld[k] = v_q;
    assign dat[k] = d_q;
    assign opc[k] = op_q;
    assign amt[k] = amt_q;
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe (WIDTH=64): directed vectors, stall, reset flush, random traffic.
module tb_barrel_shift_pipe;
  localparam int WIDTH = 64;
  localparam int LOG2W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_samt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(WIDTH), .LOG2W(LOG2W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_samt(in_samt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int n_out = 0;
  int stall_cnt = 0;
  bit lat_chk = 0;
  bit full_chk = 0;
  bit hold_pend = 0;
  logic [63:0] held;
  logic [63:0] cur_exp;
  logic [63:0] exp_q [$];
  int          stamp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: whole-word shift/rotate by n in one step.
  function automatic logic [63:0] model(input logic [63:0] d, input logic [2:0] op, input int unsigned n);
    case (op)
      3'd1: return (d >> n) | (d << (64 - n));
      3'd2: return d << n;
      3'd3: return d >> n;
`ifdef BARREL_SHIFT_PIPE_SRA_EN
      3'd4: return $unsigned($signed(d) >>> n);
`else
      3'd4: return d >> n;
`endif
      default: return (d << n) | (d >> (64 - n));
    endcase
  endfunction

  // Monitor: inputs change at posedge+1, so everything is stable at the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    int s;
    cyc++;
    if (rst) begin
      exp_q.delete();
      stamp_q.delete();
      hold_pend = 0;
      stall_cnt = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {63'b0, out_valid}, 64'd1);
        check("hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: got %h expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          check("result", out_data, e);
          if (lat_chk) check("latency", 64'(cyc - s), 64'(LOG2W));
        end
      end
      hold_pend = out_valid && !out_ready;
      held = out_data;
      stall_cnt = out_ready ? 0 : stall_cnt + 1;
      if (full_chk && in_valid && stall_cnt > 8) check("in_ready_full", {63'b0, in_ready}, 64'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        stamp_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [2:0] op, input logic [5:0] n,
                      input logic [63:0] e, output int waits);
    bit acc = 0;
    waits = 0;
    in_valid = 1'b1; in_data = d; in_op = op; in_samt = n; cur_exp = e;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (!acc && waits > 500) begin
        checks++;
        $display("FAIL send_timeout: got no accept after %0d cycles expected accept", waits);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    logic [63:0] d;
    logic [2:0] op;
    logic [5:0] n;
    bit done;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_samt = '0;
    out_ready = 1'b1; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;

    // Directed vectors, out_ready held high so latency must be exactly LOG2W.
    lat_chk = 1;
    send(64'h8000000000000001, 3'd0, 6'd1, 64'h0000000000000003, w);
    check("first_accept_cycles", 64'(w), 64'd1);
    send(64'h0000000000000001, 3'd1, 6'd4, 64'h1000000000000000, w);
    send(64'hFFFFFFFFFFFFFFFF, 3'd2, 6'd63, 64'h8000000000000000, w);
`ifdef BARREL_SHIFT_PIPE_SRA_EN
    send(64'h8000000000000000, 3'd4, 6'd63, 64'hFFFFFFFFFFFFFFFF, w);
`else
    send(64'h8000000000000000, 3'd4, 6'd63, 64'h0000000000000001, w);
`endif
    send(64'hF0F0_0000_0000_00FF, 3'd3, 6'd8, 64'h00F0_F000_0000_0000, w);
    send(64'h0123_4567_89AB_CDEF, 3'd1, 6'd32, 64'h89AB_CDEF_0123_4567, w);
    send(64'h0123_4567_89AB_CDEF, 3'd6, 6'd4, 64'h1234_5678_9ABC_DEF0, w);
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      send(d, 3'(i), 6'd0, d, w);
    end
    drain();

    // Back-to-back with a 15-cycle downstream stall.
    lat_chk = 0;
    full_chk = 1;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          d = {$urandom, $urandom}; op = 3'($urandom_range(0, 7)); n = 6'($urandom);
          send(d, op, n, model(d, op, n), w);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    full_chk = 0;
    drain();
    check("stall_count", 64'(n_out - base), 64'd20);

    // Reset with three requests in flight.
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      send(d, 3'd2, 6'd5, model(d, 3'd2, 5), w);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    rst = 1'b0;
    lat_chk = 1;
    base = n_out;
    send(64'h0000_0000_0000_00F1, 3'd0, 6'd60, 64'h1000_0000_0000_000F, w);
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("flush_count", 64'(n_out - base), 64'd1);

    // Random traffic with random backpressure.
    lat_chk = 0;
    done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          d = {$urandom, $urandom};
          op = 3'($urandom_range(0, 7));
          n = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
          send(d, op, n, model(d, op, n), w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
